// File: rtl/rv_regfile_p_if.sv
// Decode/writeback side bundle of the register file: read/write addresses and data, stall, ready.
// master drives addresses, write data and stall; slave (the file) returns read data and Ready.
interface rv_regfile_p_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            Stall;
  logic [AW-1:0]   Rd_Addr_A;
  logic [AW-1:0]   Rd_Addr_B;
  logic [AW-1:0]   Wr_Addr;
  logic [XLEN-1:0] Wr_Data;
  logic            Wr_En;
  logic [XLEN-1:0] Rd_Data_A;
  logic [XLEN-1:0] Rd_Data_B;
  logic            Ready;

  modport master (
    output Stall, Rd_Addr_A, Rd_Addr_B, Wr_Addr, Wr_Data, Wr_En,
    input  Rd_Data_A, Rd_Data_B, Ready
  );

  modport slave (
    input  Stall, Rd_Addr_A, Rd_Addr_B, Wr_Addr, Wr_Data, Wr_En,
    output Rd_Data_A, Rd_Data_B, Ready
  );
endinterface

// File: rtl/rv_regfile_p.sv
// Integer register file: 2 registered read ports (1-cycle latency), 1 write port, post-reset clear sweep.
// Stall freezes read outputs while writes continue; no backpressure on writes.
module rv_regfile_p #(
  parameter int XLEN    = 32,
  parameter int AW      = 5,
  parameter bit BYPASS  = 1'b1,
  parameter bit ZERO_X0 = 1'b1
) (
  input  logic          CLK,
  input  logic          RST,
  rv_regfile_p_if.slave rf
);
  localparam int NREG = 1 << AW;

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   cnt, cnt_nxt;
  logic            ready, ready_nxt;
  logic [XLEN-1:0] mem [NREG];
  logic [XLEN-1:0] rd_a, rd_b, rd_a_nxt, rd_b_nxt;
  logic            wr_ok;

  // Writes to x0 are dropped when it is hardwired; the bypass must honour that too.
  assign wr_ok = rf.Wr_En && !(ZERO_X0 && rf.Wr_Addr == '0);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ready_nxt = ready;
    case (state)
      S_CLEAR: begin
        if (&cnt) begin
          state_nxt = S_RUN;
          ready_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + AW'(1);
        end
      end
      S_RUN:   ready_nxt = 1'b1;
      default: state_nxt = S_CLEAR;
    endcase
  end

  always_comb begin
    rd_a_nxt = mem[rf.Rd_Addr_A];
    rd_b_nxt = mem[rf.Rd_Addr_B];
    if (BYPASS && wr_ok && rf.Wr_Addr == rf.Rd_Addr_A) rd_a_nxt = rf.Wr_Data;
    if (BYPASS && wr_ok && rf.Wr_Addr == rf.Rd_Addr_B) rd_b_nxt = rf.Wr_Data;
    if (ZERO_X0 && rf.Rd_Addr_A == '0) rd_a_nxt = '0;
    if (ZERO_X0 && rf.Rd_Addr_B == '0) rd_b_nxt = '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_CLEAR;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ready <= ready_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || state == S_CLEAR) begin
      rd_a <= '0;
      rd_b <= '0;
    end else if (!rf.Stall) begin
      rd_a <= rd_a_nxt;
      rd_b <= rd_b_nxt;
    end
  end

  // The array is left alone on the reset edge itself; the sweep zeroes it afterwards.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (state == S_CLEAR) mem[cnt] <= '0;
      else if (wr_ok)       mem[rf.Wr_Addr] <= rf.Wr_Data;
    end
  end

  assign rf.Rd_Data_A = rd_a;
  assign rf.Rd_Data_B = rd_b;
  assign rf.Ready     = ready;
endmodule

// File: tb/tb_rv_regfile_p.sv
// Directed bench for rv_regfile_p: bypassing and non-bypassing builds driven in lockstep,
// expectations queued at drive time and checked after each edge.
module tb_rv_regfile_p;
  logic        CLK = 1'b0;
  logic        RST;
  logic        st, we;
  logic [4:0]  ra, rb, wa;
  logic [31:0] wd;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [31:0] a1, b1, a0, b0;
    logic        rdy;
  } exp_t;
  exp_t sb[$];

  always #5 CLK = ~CLK;

  rv_regfile_p_if #(.XLEN(32), .AW(5)) if1 ();
  rv_regfile_p_if #(.XLEN(32), .AW(5)) if0 ();

  assign if1.Stall = st;  assign if1.Wr_En = we;  assign if1.Wr_Addr = wa;  assign if1.Wr_Data = wd;
  assign if1.Rd_Addr_A = ra;  assign if1.Rd_Addr_B = rb;
  assign if0.Stall = st;  assign if0.Wr_En = we;  assign if0.Wr_Addr = wa;  assign if0.Wr_Data = wd;
  assign if0.Rd_Addr_A = ra;  assign if0.Rd_Addr_B = rb;

  rv_regfile_p #(.XLEN(32), .AW(5), .BYPASS(1'b1), .ZERO_X0(1'b1)) dut_byp (
    .CLK (CLK), .RST (RST), .rf (if1.slave)
  );
  rv_regfile_p #(.XLEN(32), .AW(5), .BYPASS(1'b0), .ZERO_X0(1'b1)) dut_nobyp (
    .CLK (CLK), .RST (RST), .rf (if0.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Push the expectation for the current drive, clock once, then pop and compare.
  task automatic step(input string tag, input logic [31:0] a1, input logic [31:0] b1,
                      input logic [31:0] a0, input logic [31:0] b0, input logic rdy);
    exp_t e;
    e.tag = tag; e.a1 = a1; e.b1 = b1; e.a0 = a0; e.b0 = b0; e.rdy = rdy;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    chk({e.tag, " byp.A"},   if1.Rd_Data_A, e.a1);
    chk({e.tag, " byp.B"},   if1.Rd_Data_B, e.b1);
    chk({e.tag, " nobyp.A"}, if0.Rd_Data_A, e.a0);
    chk({e.tag, " nobyp.B"}, if0.Rd_Data_B, e.b0);
    chk({e.tag, " byp.rdy"},   {31'd0, if1.Ready}, {31'd0, e.rdy});
    chk({e.tag, " nobyp.rdy"}, {31'd0, if0.Ready}, {31'd0, e.rdy});
  endtask

  task automatic step2(input string tag, input logic [31:0] a, input logic [31:0] b, input logic rdy);
    step(tag, a, b, a, b, rdy);
  endtask

  initial begin
    RST = 1'b1; st = 1'b0; we = 1'b0; ra = '0; rb = '0; wa = '0; wd = '0;
    step2("reset", 32'h0, 32'h0, 1'b0);

    RST = 1'b0;
    for (int i = 1; i <= 32; i++) step2($sformatf("clear%0d", i), 32'h0, 32'h0, i == 32);
    for (int i = 0; i < 32; i++) begin
      ra = 5'(i); rb = 5'(31 - i);
      step2($sformatf("zero_rd%0d", i), 32'h0, 32'h0, 1'b1);
    end

    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; ra = 5'd0; rb = 5'd0;
    step2("wr_x5", 32'h0, 32'h0, 1'b1);
    we = 1'b0; ra = 5'd5; rb = 5'd5;
    step2("rd_x5", 32'hDEADBEEF, 32'hDEADBEEF, 1'b1);
    we = 1'b1; wa = 5'd0; wd = 32'h1234; ra = 5'd0; rb = 5'd5;
    step2("wr_x0", 32'h0, 32'hDEADBEEF, 1'b1);
    we = 1'b0; ra = 5'd0; rb = 5'd0;
    step2("rd_x0", 32'h0, 32'h0, 1'b1);

    we = 1'b1; wa = 5'd7; wd = 32'h11; ra = 5'd0; rb = 5'd0;
    step2("wr_x7", 32'h0, 32'h0, 1'b1);
    wd = 32'hA5A5A5A5; ra = 5'd7; rb = 5'd5;
    step("bypass_a", 32'hA5A5A5A5, 32'hDEADBEEF, 32'h11, 32'hDEADBEEF, 1'b1);
    we = 1'b0; ra = 5'd7; rb = 5'd7;
    step2("rd_x7", 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b1);
    we = 1'b1; wa = 5'd5; wd = 32'hCAFEF00D; ra = 5'd5; rb = 5'd5;
    step("bypass_ab", 32'hCAFEF00D, 32'hCAFEF00D, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1);

    wa = 5'd3; wd = 32'h11; ra = 5'd0; rb = 5'd0;
    step2("wr_x3", 32'h0, 32'h0, 1'b1);
    we = 1'b0; ra = 5'd3; rb = 5'd7;
    step2("rd_x3", 32'h11, 32'hA5A5A5A5, 1'b1);
    st = 1'b1; we = 1'b1; wa = 5'd3; wd = 32'h22; ra = 5'd4; rb = 5'd3;
    for (int i = 0; i < 3; i++) step2($sformatf("stall%0d", i), 32'h11, 32'hA5A5A5A5, 1'b1);
    st = 1'b0; we = 1'b0; ra = 5'd3; rb = 5'd4;
    step2("unstall", 32'h22, 32'h0, 1'b1);

    we = 1'b1; wa = 5'd9; wd = 32'hFFFF0000; ra = 5'd0; rb = 5'd0;
    step2("wr_x9", 32'h0, 32'h0, 1'b1);
    we = 1'b0; ra = 5'd9; rb = 5'd9;
    step2("rd_x9", 32'hFFFF0000, 32'hFFFF0000, 1'b1);
    RST = 1'b1;
    step2("rst_run", 32'h0, 32'h0, 1'b0);
    RST = 1'b0; we = 1'b1; wa = 5'd2; wd = 32'h00000BAD; ra = 5'd9; rb = 5'd2;
    for (int i = 1; i <= 32; i++) step2($sformatf("reclear%0d", i), 32'h0, 32'h0, i == 32);
    we = 1'b0;
    step2("rd_after_clear", 32'h0, 32'h0, 1'b1);

    RST = 1'b1;
    step2("rst2", 32'h0, 32'h0, 1'b0);
    RST = 1'b0;
    for (int i = 1; i <= 10; i++) step2($sformatf("part_clear%0d", i), 32'h0, 32'h0, 1'b0);
    RST = 1'b1;
    step2("rst_mid_clear", 32'h0, 32'h0, 1'b0);
    RST = 1'b0;
    for (int i = 1; i <= 32; i++) step2($sformatf("restart%0d", i), 32'h0, 32'h0, i == 32);
    ra = 5'd5; rb = 5'd7;
    step2("rd_final", 32'h0, 32'h0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
